// File: rtl/hd44780_responder_if.sv
// hd44780_responder_if: LCD bus pins plus decoded command/character outputs of the responder.
interface hd44780_responder_if;
  logic [2:0] lcd_ctrl;
  logic [3:0] lcd_data_in;
  logic [3:0] lcd_data_out;
  logic lcd_data_oe;
  logic char_valid;
  logic [7:0] char_data;
  logic [6:0] char_addr;
  logic cmd_valid;
  logic [7:0] cmd_code;
  logic busy;
  logic [7:0] dbg;
  modport master (
    output lcd_ctrl, lcd_data_in,
    input lcd_data_out, lcd_data_oe, char_valid, char_data, char_addr, cmd_valid, cmd_code, busy, dbg
  );
  modport slave (
    input lcd_ctrl, lcd_data_in,
    output lcd_data_out, lcd_data_oe, char_valid, char_data, char_addr, cmd_valid, cmd_code, busy, dbg
  );
endinterface

// File: rtl/hd44780_responder.sv
// hd44780_responder: HD44780-style LCD bus target turning bus writes into command/character pulses.
// HD44780_READ_EN adds busy-flag/address read-back on RW=1 cycles.
module hd44780_responder #(
  parameter int BUSY_CLKS = 1008,
  parameter int CLEAR_CLKS = 39360
) (
  input logic clk,
  input logic rst,
  hd44780_responder_if.slave bus
);
  localparam int CW = $clog2((CLEAR_CLKS > BUSY_CLKS ? CLEAR_CLKS : BUSY_CLKS) + 1);
  localparam logic [CW-1:0] SHORT = CW'(BUSY_CLKS - 1);
  localparam logic [CW-1:0] LONG = CW'(CLEAR_CLKS - 1);
  typedef enum logic [1:0] {IDLE, HALF, BUSY} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic e_q, rs_h, overrun, four_bit, two_line, id, disp_on;
  logic [3:0] hi;
  logic [6:0] addr, addr_nx;
  logic [7:0] byte_v;
  logic rs, wr, done, long_cmd;
  always_comb begin
    rs = bus.lcd_ctrl[2];
    wr = e_q & ~bus.lcd_ctrl[0] & ~bus.lcd_ctrl[1];
    byte_v = state == HALF ? {hi, bus.lcd_data_in} : {bus.lcd_data_in, 4'h0};
    done = wr & (state == HALF ? (rs == rs_h) : (state == IDLE && !four_bit));
    long_cmd = ~rs & (byte_v[7:2] == 6'd0) & (byte_v[1:0] != 2'd0);
    addr_nx = id ? (two_line ? (addr == 7'h27 ? 7'h40 : addr == 7'h67 ? 7'h00 : addr + 7'd1)
                             : (addr == 7'h4f ? 7'h00 : addr + 7'd1))
                 : (two_line ? (addr == 7'h40 ? 7'h27 : addr == 7'h00 ? 7'h67 : addr - 7'd1)
                             : (addr == 7'h00 ? 7'h4f : addr - 7'd1));
  end
  assign bus.busy = state == BUSY;
  assign bus.dbg = {overrun, four_bit, two_line, id, disp_on, state == HALF, 2'b00};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      e_q <= 1'b0;
      rs_h <= 1'b0;
      hi <= 4'h0;
      overrun <= 1'b0;
      four_bit <= 1'b0;
      two_line <= 1'b0;
      id <= 1'b1;
      disp_on <= 1'b0;
      addr <= 7'h00;
      bus.char_valid <= 1'b0;
      bus.char_data <= 8'h00;
      bus.char_addr <= 7'h00;
      bus.cmd_valid <= 1'b0;
      bus.cmd_code <= 8'h00;
    end else begin
      e_q <= bus.lcd_ctrl[0];
      bus.char_valid <= 1'b0;
      bus.cmd_valid <= 1'b0;
      if (state == BUSY) begin
        if (wr) overrun <= 1'b1;
        if (cnt == '0) state <= IDLE;
        else cnt <= cnt - 1'b1;
      end else if (done) begin
        state <= BUSY;
        cnt <= long_cmd ? LONG : SHORT;
        if (rs) begin
          bus.char_valid <= 1'b1;
          bus.char_data <= byte_v;
          bus.char_addr <= addr;
          addr <= addr_nx;
        end else begin
          bus.cmd_valid <= 1'b1;
          bus.cmd_code <= byte_v;
          casez (byte_v)
            8'b1???????: addr <= byte_v[6:0];
            8'b001?????: begin
              four_bit <= ~byte_v[4];
              two_line <= byte_v[3];
            end
            8'b00001???: disp_on <= byte_v[2];
            8'b000001??: id <= byte_v[1];
            8'b0000001?: addr <= 7'h00;
            8'b00000001: begin
              addr <= 7'h00;
              id <= 1'b1;
            end
            default: ;
          endcase
        end
      end else if (wr) begin
        // RS mismatch in HALF drops the held nibble and restarts with this one
        if (state == HALF) overrun <= 1'b1;
        hi <= bus.lcd_data_in;
        rs_h <= rs;
        state <= HALF;
      end
    end
`ifdef HD44780_READ_EN
  logic rd_phase;
  assign bus.lcd_data_oe = ~rst & bus.lcd_ctrl[1] & bus.lcd_ctrl[0];
  assign bus.lcd_data_out = (~bus.lcd_data_oe | rs) ? 4'h0 : rd_phase ? addr[3:0] : {state == BUSY, addr[6:4]};
  always_ff @(posedge clk or posedge rst)
    if (rst) rd_phase <= 1'b0;
    else rd_phase <= !four_bit ? 1'b0 : (e_q & ~bus.lcd_ctrl[0] & bus.lcd_ctrl[1]) ? ~rd_phase : rd_phase;
`else
  assign bus.lcd_data_oe = 1'b0;
  assign bus.lcd_data_out = 4'h0;
`endif
endmodule

// File: tb/tb_hd44780_responder.sv
// tb_hd44780_responder: directed bench for hd44780_responder with shortened busy durations.
module tb_hd44780_responder;
  localparam int B = 20;
  localparam int C = 60;
`ifdef HD44780_READ_EN
  localparam logic RD = 1'b1;
`else
  localparam logic RD = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  int pass_n = 0;
  int total_n = 0;
  int n;
  hd44780_responder_if bus_if();
  hd44780_responder #(.BUSY_CLKS(B), .CLEAR_CLKS(C)) dut (.clk(clk), .rst(rst), .bus(bus_if));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_n++;
    assert (obs === exp) pass_n++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic wr(input logic r, input logic [3:0] nib);
    @(negedge clk);
    bus_if.lcd_ctrl = {r, 1'b0, 1'b1};
    bus_if.lcd_data_in = nib;
    @(negedge clk);
    bus_if.lcd_ctrl = {r, 1'b0, 1'b0};
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic r, input logic [7:0] b);
    wr(r, b[7:4]);
    wr(r, b[3:0]);
  endtask
  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (bus_if.busy && cyc < 500) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask
  task automatic rd_nib(input string tag, input logic [3:0] exp_out);
    @(negedge clk);
    bus_if.lcd_ctrl = 3'b011;
    #1;
    chk({tag, "_oe"}, bus_if.lcd_data_oe, RD);
    chk({tag, "_data"}, bus_if.lcd_data_out, RD ? exp_out : 4'h0);
    @(negedge clk);
    bus_if.lcd_ctrl = 3'b010;
    #1;
    chk({tag, "_oe_low"}, bus_if.lcd_data_oe, 1'b0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bus_if.lcd_ctrl = 3'b000;
    bus_if.lcd_data_in = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_valid", bus_if.cmd_valid, 1'b0);
    chk("rst_char_valid", bus_if.char_valid, 1'b0);
    chk("rst_busy", bus_if.busy, 1'b0);
    chk("rst_outs", {bus_if.cmd_code, bus_if.char_data, 1'b0, bus_if.char_addr}, 32'h0);
    chk("rst_dbg", bus_if.dbg & 8'hEF, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    wr(1'b0, 4'h3);
    chk("init1_valid", bus_if.cmd_valid, 1'b1);
    chk("init1_code", bus_if.cmd_code, 8'h30);
    chk("init1_busy", bus_if.busy, 1'b1);
    @(posedge clk);
    #1;
    chk("init1_pulse_end", bus_if.cmd_valid, 1'b0);
    wait_idle(n);
    chk("init1_busy_len", n + 1, B);
    wr(1'b0, 4'h3);
    chk("init2_code", {bus_if.cmd_valid, bus_if.cmd_code}, 9'h130);
    wait_idle(n);
    wr(1'b0, 4'h3);
    chk("init3_code", {bus_if.cmd_valid, bus_if.cmd_code}, 9'h130);
    wait_idle(n);
    wr(1'b0, 4'h2);
    chk("init4_code", {bus_if.cmd_valid, bus_if.cmd_code}, 9'h120);
    chk("init4_four_bit", bus_if.dbg[6], 1'b1);
    wait_idle(n);
    wr(1'b0, 4'h8);
    chk("half_phase", bus_if.dbg[2], 1'b1);
    chk("half_no_pulse", bus_if.cmd_valid, 1'b0);
    wr(1'b0, 4'h0);
    chk("set_addr0", {bus_if.cmd_valid, bus_if.cmd_code}, 9'h180);
    wait_idle(n);
    send(1'b1, 8'h41);
    chk("char_a", {bus_if.char_valid, bus_if.char_data, bus_if.char_addr}, {1'b1, 8'h41, 7'h00});
    wait_idle(n);
    chk("char_a_busy_len", n, B);
    send(1'b1, 8'h42);
    chk("char_b", {bus_if.char_valid, bus_if.char_data, bus_if.char_addr}, {1'b1, 8'h42, 7'h01});
    wait_idle(n);
    chk("char_b_busy_len", n, B);
    send(1'b0, 8'h28);
    chk("two_line", bus_if.dbg[6:5], 2'b11);
    wait_idle(n);
    send(1'b0, 8'hA7);
    wait_idle(n);
    send(1'b1, 8'h55);
    chk("wrap_27", {bus_if.char_valid, bus_if.char_addr}, {1'b1, 7'h27});
    wait_idle(n);
    send(1'b1, 8'h56);
    chk("wrap_40", bus_if.char_addr, 7'h40);
    wait_idle(n);
    send(1'b0, 8'h04);
    chk("id_clear", bus_if.dbg[4], 1'b0);
    wait_idle(n);
    send(1'b0, 8'h80);
    wait_idle(n);
    send(1'b1, 8'h58);
    chk("dec_at_00", bus_if.char_addr, 7'h00);
    wait_idle(n);
    send(1'b1, 8'h59);
    chk("dec_wrap_67", bus_if.char_addr, 7'h67);
    wait_idle(n);
    send(1'b0, 8'h01);
    chk("clear_code", {bus_if.cmd_valid, bus_if.cmd_code}, 9'h101);
    chk("clear_id", bus_if.dbg[4], 1'b1);
    repeat (3) @(posedge clk);
    wr(1'b1, 4'hF);
    chk("busy_strobe_ignored", {bus_if.char_valid, bus_if.cmd_valid}, 2'b00);
    chk("busy_overrun", bus_if.dbg[7], 1'b1);
    chk("busy_phase_kept", bus_if.dbg[2], 1'b0);
    wait_idle(n);
    chk("clear_busy_len", n, C - 5);
    send(1'b1, 8'h43);
    chk("after_clear_addr", bus_if.char_addr, 7'h00);
    wait_idle(n);
    wr(1'b0, 4'h3);
    wr(1'b1, 4'h4);
    chk("rs_mismatch_no_pulse", {bus_if.char_valid, bus_if.cmd_valid, bus_if.dbg[2]}, 3'b001);
    wr(1'b1, 4'h1);
    chk("rs_mismatch_char", {bus_if.char_valid, bus_if.char_data, bus_if.char_addr}, {1'b1, 8'h41, 7'h01});
    wait_idle(n);
    send(1'b0, 8'h95);
    rd_nib("read_hi", 4'h9);
    rd_nib("read_lo", 4'h5);
    bus_if.lcd_ctrl = 3'b000;
    chk("read_no_state", {bus_if.dbg[2], bus_if.char_valid, bus_if.cmd_valid}, 3'b000);
    wait_idle(n);
    send(1'b1, 8'h44);
    chk("read_no_addr", bus_if.char_addr, 7'h15);
    wait_idle(n);
    wr(1'b1, 4'h4);
    chk("pre_rst_phase", bus_if.dbg[2], 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_dbg", bus_if.dbg & 8'hEF, 8'h00);
    chk("mid_rst_outs", {bus_if.busy, bus_if.char_valid, bus_if.cmd_valid, bus_if.char_data, bus_if.char_addr, bus_if.cmd_code}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    wr(1'b0, 4'h8);
    chk("post_rst_8bit", {bus_if.cmd_valid, bus_if.cmd_code}, 9'h180);
    wait_idle(n);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule

// File: doc/hd44780_responder.md
HD44780_RESPONDER -- requirements
Module: hd44780_responder

Interface
REQ-001 Parameter BUSY_CLKS, default 1008: busy duration in clk cycles for ordinary commands and data writes.
REQ-002 Parameter CLEAR_CLKS, default 39360: busy duration in clk cycles for clear and return-home.
REQ-003 Port clk, input, 1: single clock; all logic rises on posedge clk.
REQ-004 Port rst, input, 1: asynchronous, active-high reset.
REQ-005 Port lcd_ctrl, input, 3: bus control {RS, RW, E}, synchronous to clk.
REQ-006 Port lcd_data_in, input, 4: bus lines DB7..DB4.
REQ-007 Port lcd_data_out, output, 4: read-back nibble.
REQ-008 Port lcd_data_oe, output, 1: lcd_data_out drive enable.
REQ-009 Port char_valid, output, 1: one-cycle pulse when a data byte is accepted.
REQ-010 Port char_data, output, 8: accepted data byte, valid with char_valid.
REQ-011 Port char_addr, output, 7: DDRAM address the byte was written to.
REQ-012 Port cmd_valid, output, 1: one-cycle pulse when a command byte is accepted.
REQ-013 Port cmd_code, output, 8: accepted command byte, valid with cmd_valid.
REQ-014 Port busy, output, 1: busy flag.
REQ-015 Port dbg, output, 8: {overrun, four_bit, two_line, id, disp_on, nibble_phase, 2'b0}.

Function
REQ-016 Strobe is a falling edge of E, detected against E registered on the previous clk; bus sampled from the same-cycle inputs.
REQ-017 Initial interface is 8-bit: each write strobe forms byte {lcd_data_in, 4'h0}.
REQ-018 In 4-bit mode the first strobe gives the high nibble and the second the low nibble; the byte completes on the second strobe.
REQ-019 RS must match on both nibbles; on mismatch, discard the high nibble, set overrun, and treat the current nibble as a new high nibble.
REQ-020 States are IDLE, HALF (high nibble held), and BUSY; a completed byte moves to BUSY with counter loaded; BUSY returns to IDLE when the counter reaches zero.
REQ-021 cmd_valid/char_valid pulse the cycle after the completing strobe; busy is asserted from that same cycle.
REQ-022 Commands are decoded by leading one:
  - 0x01 clear: addr=0, id=1, CLEAR_CLKS.
  - 0x02-0x03 home: addr=0, CLEAR_CLKS.
  - 0x04-0x07: id=bit1.
  - 0x08-0x0F: disp_on=bit2.
  - 0x10-0x1F shift: pulse only.
  - 0x20-0x3F: four_bit=~bit4, two_line=bit3.
  - 0x40-0x7F CGRAM: pulse only.
  - 0x80-0xFF: addr=bit[6:0].
  - All others use BUSY_CLKS.
REQ-023 A data write outputs the current addr, then addr steps +1 if id=1, else -1.
REQ-024 Address wrap, 1-line mode: 0x4F->0x00 and 0x00->0x4F.
REQ-025 Address wrap, 2-line mode: 0x27->0x40, 0x67->0x00, 0x40->0x27, and 0x00->0x67.
REQ-026 A write strobe while busy is ignored, sets overrun (sticky until reset), and leaves nibble phase unchanged.
REQ-027 A function set received while in HALF completes normally; a mode change takes effect on the next strobe.
REQ-028 A write strobe while E is low and RW=1 is not a write; see REQ-032.

Reset
REQ-029 On rst, all outputs are 0, state IDLE, addr=0, id=1, four_bit=0, two_line=0, disp_on=0, overrun=0, counter=0.
REQ-030 rst asserted mid-byte or mid-busy aborts immediately; the first strobe after release is treated as an 8-bit-mode write.

Configuration
REQ-031 Macro HD44780_READ_EN defined: read cycles are supported.
REQ-032 With HD44780_READ_EN, while RW=1 and E=1, lcd_data_oe=1 and lcd_data_out presents {busy, addr[6:4]} then addr[3:0] on alternate strobes in 4-bit mode (high nibble only in 8-bit mode); reads never change addr or state; RS=1 reads return 4'h0.
REQ-033 Macro HD44780_READ_EN undefined: lcd_data_oe and lcd_data_out are constant 0, and RW=1 strobes are ignored.

Verification
REQ-034 Reset, three 8-bit strobes of 0x3, then 0x2 -> four cmd_valid pulses (0x30,0x30,0x30,0x20); dbg four_bit=1 after the fourth.
REQ-035 In 4-bit mode, send 0x80 then RS=1 data 0x41,0x42 -> char_valid with (0x41,0x00) then (0x42,0x01); busy lasts BUSY_CLKS each.
REQ-036 In 2-line mode, send 0xA7 then data 0x55 -> char_addr=0x27, next addr=0x40; with id=0 at addr 0x00, a write steps addr to 0x67.
REQ-037 Send 0x01 then a write strobe 5 cycles later -> strobe ignored, overrun=1, busy held CLEAR_CLKS, addr=0.
REQ-038 Assert rst after the high nibble of 0x48 -> outputs 0; next strobe is decoded in 8-bit mode.
REQ-039 With HD44780_READ_EN, read during busy at addr 0x15 -> nibbles 0x9 then 0x5, lcd_data_oe=1 only while E=1; without the macro, lcd_data_oe stays 0.
